// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed, checksummed byte stream and writes
// it into instruction memory, then releases the processor when the checksum matches.
// Ports: clk/rst; start kicks a load; in_valid/in_data/in_ready is the byte stream;
// mem_we/mem_addr/mem_wdata drive the instruction memory; cpu_run/busy/done/error report status.
module program_loader #(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_run,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERR} state_t;

    localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] addr_cnt;
    logic [7:0] acc;
    logic [8:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // in_ready is 1 in every state that consumes stream bytes, so inside those
    // states in_valid alone means a byte is accepted on this edge.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE, RUN, ERR: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // remaining==1 means this byte is the last payload byte
                if (in_valid && remaining == 9'd1) state_nxt = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = (in_data == acc) ? RUN : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt  <= 8'd0;
            acc       <= 8'd0;
            remaining <= 9'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'd0;
            mem_wdata <= 8'd0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        addr_cnt <= 8'd0;
                        acc      <= 8'd0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_run  <= 1'b0;
                    end
                end
                LEN: begin
                    // a length byte of 0 encodes a full 256-byte image
                    if (in_valid) remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                end
                DATA: begin
                    if (in_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_cnt;
                        mem_wdata <= in_data;
                        addr_cnt  <= (addr_cnt == LAST_ADDR) ? 8'd0 : addr_cnt + 8'd1;
                        acc       <= acc + in_data;
                        remaining <= remaining - 9'd1;
                    end
                end
                CSUM: begin
                    if (in_valid) begin
                        if (in_data == acc) begin
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else begin
                            error   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a stream-position reference model predicts every
// output each cycle; directed loads additionally check literal write lists and status.
module tb_program_loader;

    localparam int MEM_DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, mem_we, cpu_run, busy, done, error;
    logic [7:0] mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    program_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the stream of the current load.
    // k=0 expects the length, 1..n are payload bytes, n+1 is the checksum.
    logic       m_active, exp_we, exp_done, exp_err, exp_run;
    logic [7:0] exp_addr, exp_wdata;
    int         m_k, m_n, m_sum, m_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; exp_we <= 1'b0; exp_done <= 1'b0; exp_err <= 1'b0; exp_run <= 1'b0;
            exp_addr <= 8'd0; exp_wdata <= 8'd0;
            m_k <= 0; m_n <= 0; m_sum <= 0; m_addr <= 0;
        end else begin
            exp_we <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1; m_k <= 0; m_sum <= 0; m_addr <= 0;
                    exp_done <= 1'b0; exp_err <= 1'b0; exp_run <= 1'b0;
                end
            end else if (in_valid) begin
                if (m_k == 0) begin
                    m_n <= (in_data == 8'd0) ? 256 : int'(in_data);
                    m_k <= 1;
                end else if (m_k <= m_n) begin
                    exp_we    <= 1'b1;
                    exp_addr  <= 8'(m_addr);
                    exp_wdata <= in_data;
                    m_addr    <= (m_addr + 1) % MEM_DEPTH;
                    m_sum     <= (m_sum + int'(in_data)) % 256;
                    m_k       <= m_k + 1;
                end else begin
                    if (int'(in_data) == m_sum) begin
                        exp_done <= 1'b1;
                        exp_run  <= 1'b1;
                    end else begin
                        exp_err  <= 1'b1;
                    end
                    m_active <= 1'b0;
                end
            end
        end
    end

    // Per-cycle compare plus a log of observed writes for the directed tests.
    int         cyc_n = 0;
    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];
    int         log_cyc[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, m_active);
            check("busy", busy, m_active);
            check("mem_we", mem_we, exp_we);
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wdata", mem_wdata, exp_wdata);
            check("done", done, exp_done);
            check("error", error, exp_err);
            check("cpu_run", cpu_run, exp_run);
            check("done_and_error", done & error, 1'b0);
            if (mem_we) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                log_cyc.push_back(cyc_n);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'($urandom % 2);
            in_data  = 8'($urandom);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'($urandom % 2);
        in_data  = 8'($urandom);
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int maxgap, input bit start_noise);
        repeat ($urandom_range(maxgap, 0)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = start_noise && ($urandom % 4 == 0);
            cyc();
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic rst_check(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic r);
        @(negedge clk);
        check({tag, "_done"}, done, d);
        check({tag, "_error"}, error, e);
        check({tag, "_cpu_run"}, cpu_run, r);
    endtask

    task automatic check_writes(input string tag, input logic [15:0] exp[$]);
        check({tag, "_wr_count"}, 16'(log_addr.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_addr.size(); i++) begin
            check({tag, "_wr"}, {log_addr[i], log_data[i]}, exp[i]);
            if (i > 0) check({tag, "_wr_consec"}, 16'(log_cyc[i] - log_cyc[i-1]), 16'd1);
        end
    endtask

    logic [15:0] exp_q[$];
    logic [7:0]  b, s;
    int          n;

    initial begin
        #1 rst = 1'b1;
        #1 rst_check("reset");
        repeat (2) cyc();
        rst = 1'b0;
        idle(4);

        // nominal load
        clear_log();
        do_start();
        send(8'h03, 0, 0); send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h66, 0, 0);
        check_status("nominal", 1, 0, 1);
        exp_q = {16'h0011, 16'h0122, 16'h0233};
        check_writes("nominal", exp_q);
        idle(3);

        // bad checksum
        clear_log();
        do_start();
        send(8'h02, 0, 0); send(8'h05, 0, 0); send(8'h06, 0, 0); send(8'h0C, 0, 0);
        check_status("badsum", 0, 1, 0);
        exp_q = {16'h0005, 16'h0106};
        check_writes("badsum", exp_q);
        idle(3);

        // length 0 = 256 bytes with gaps; address wraps through the whole space
        clear_log();
        do_start();
        send(8'h00, 3, 0);
        repeat (256) send(8'h01, 3, 0);
        send(8'h00, 3, 0);
        check_status("len0", 1, 0, 1);
        check("len0_wr_count", 16'(log_addr.size()), 16'd256);
        for (int i = 0; i < 256 && i < log_addr.size(); i++) begin
            check("len0_addr", log_addr[i], 16'(i));
            check("len0_data", log_data[i], 16'h01);
        end
        idle(3);

        // reset in the middle of the payload, with a write still pending
        do_start();
        send(8'h05, 0, 0); send(8'h44, 0, 0); send(8'h55, 0, 0);
        rst = 1'b1;
        #1 rst_check("midrst");
        clear_log();
        cyc();
        rst = 1'b0;
        idle(6);
        check("midrst_no_writes", 16'(log_addr.size()), 16'd0);
        do_start();
        send(8'h01, 0, 0); send(8'hAA, 0, 0); send(8'hAA, 0, 0);
        check_status("after_rst", 1, 0, 1);
        exp_q = {16'h00AA};
        check_writes("after_rst", exp_q);
        idle(3);

        // start during DATA is ignored; start in RUN begins a new load
        clear_log();
        do_start();
        send(8'h03, 0, 0); send(8'h10, 0, 0);
        start = 1'b1; in_valid = 1'b1; in_data = 8'h20;
        cyc();
        start = 1'b0; in_valid = 1'b0;
        send(8'h30, 0, 0); send(8'h60, 0, 0);
        check_status("ign_start", 1, 0, 1);
        exp_q = {16'h0010, 16'h0120, 16'h0230};
        check_writes("ign_start", exp_q);
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("reload_cpu_run", cpu_run, 0);
        check("reload_done", done, 0);
        check("reload_busy", busy, 1);
        send(8'h01, 0, 0); send(8'h07, 0, 0); send(8'h07, 0, 0);
        check_status("reload", 1, 0, 1);

        // randomized loads with gaps, start noise and occasional bad checksums
        for (int t = 0; t < 30; t++) begin
            n = (t == 7) ? 256 : int'($urandom_range(20, 1));
            s = 8'd0;
            do_start();
            send(8'(n), 2, 1);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                s = s + b;
                send(b, 2, 1);
            end
            send(($urandom % 3 == 0) ? (s ^ 8'h5A) : s, 2, 1);
            idle($urandom_range(4, 0));
        end

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
